// File: rtl/pass_switch_bank_pkg.sv
// Shared types and sizing helpers for the pass-switch bank device model.
package pass_switch_pkg;

    typedef enum logic [1:0] {
        FLT_NONE   = 2'b00,
        FLT_OPEN   = 2'b01,
        FLT_CLOSED = 2'b10
    } flt_t;

    typedef enum logic [1:0] {
        SW_DECAYED = 2'b00,
        SW_DRIVEN  = 2'b01,
        SW_HOLDING = 2'b10
    } sw_state_t;

    // Hold counter width: enough to represent HOLD_CYCLES, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned hold);
        return (hold < 2) ? 1 : $clog2(hold + 1);
    endfunction

    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels < 2) ? 1 : $clog2(channels);
    endfunction

endpackage

// File: rtl/pass_switch_bank_if.sv
// Pattern/response bus of the pass-switch bank: stimulus side is the master.
interface pass_switch_bank_if
    import pass_switch_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4
) ();
    localparam int unsigned SW = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] a;
    logic [CHANNELS-1:0]       ctrl;
    logic                      flt_we;
    logic [SW-1:0]             flt_ch;
    logic [1:0]                flt_type;
    logic [CHANNELS*WIDTH-1:0] o;
    logic [CHANNELS-1:0]       o_driven;
    logic [CHANNELS-1:0]       o_valid;
    logic [CHANNELS-1:0]       decay_evt;

    modport master (
        output a, ctrl, flt_we, flt_ch, flt_type,
        input  o, o_driven, o_valid, decay_evt
    );

    modport slave (
        input  a, ctrl, flt_we, flt_ch, flt_type,
        output o, o_driven, o_valid, decay_evt
    );
endinterface

// File: rtl/pass_switch_bank_cell.sv
// One pass-switch channel: conduction/keeper state machine, hold counter,
// data register and the channel's injected fault code.
module pass_switch_cell
    import pass_switch_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HOLD_CYCLES = 15,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_i,
    input  logic             ctrl_i,
    input  logic             flt_we_i,
    input  logic [1:0]       flt_type_i,
    output logic [WIDTH-1:0] o_o,
    output logic             driven_o,
    output logic             valid_o,
    output logic             decay_o
);
    localparam int unsigned CW = cnt_width(HOLD_CYCLES);

    sw_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic             drv_q, drv_d;
    logic             vld_q, vld_d;
    logic             dec_q, dec_d;
    logic [1:0]       flt_q, flt_d;
    logic             on_c;

    // Effective conduction; the reserved fault code behaves as no fault
    always_comb begin
        case (flt_q)
            FLT_OPEN:   on_c = 1'b0;
            FLT_CLOSED: on_c = 1'b1;
            default:    on_c = (ctrl_i == ACTIVE_HIGH);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        drv_d   = 1'b0;
        vld_d   = vld_q;
        dec_d   = 1'b0;
        flt_d   = flt_we_i ? flt_type_i : flt_q;

        if (on_c) begin
            state_d = SW_DRIVEN;
            o_d     = a_i;
            drv_d   = 1'b1;
            vld_d   = 1'b1;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SW_DRIVEN, SW_HOLDING: begin
                    if ((32'(cnt_q) + 32'd1) < 32'(HOLD_CYCLES)) begin
                        state_d = SW_HOLDING;
                        cnt_d   = cnt_q + CW'(1);
                        vld_d   = 1'b1;
                    end else begin
                        state_d = SW_DECAYED;
                        cnt_d   = '0;
                        o_d     = '0;
                        vld_d   = 1'b0;
                        dec_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = SW_DECAYED;
                    o_d     = '0;
                    vld_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SW_DECAYED;
            cnt_q   <= '0;
            o_q     <= '0;
            drv_q   <= 1'b0;
            vld_q   <= 1'b0;
            dec_q   <= 1'b0;
            flt_q   <= FLT_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            drv_q   <= drv_d;
            vld_q   <= vld_d;
            dec_q   <= dec_d;
            flt_q   <= flt_d;
        end
    end

    assign o_o      = o_q;
    assign driven_o = drv_q;
    assign valid_o  = vld_q;
    assign decay_o  = dec_q;

endmodule

// File: rtl/pass_switch_bank.sv
// Bank of independent pass-switch channels: fault-write decode and bus slicing only.
module pass_switch_bank
    import pass_switch_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned HOLD_CYCLES = 15,
    parameter bit          ACTIVE_HIGH = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    pass_switch_bank_if.slave bus
);
    localparam int unsigned SW = sel_width(CHANNELS);

    logic [CHANNELS-1:0] we_c;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        // Out-of-range channel numbers never match, so such writes fall away
        assign we_c[c] = bus.flt_we && (bus.flt_ch == SW'(c));

        pass_switch_cell #(
            .WIDTH       (WIDTH),
            .HOLD_CYCLES (HOLD_CYCLES),
            .ACTIVE_HIGH (ACTIVE_HIGH)
        ) u_cell (
            .clk        (clk),
            .rst_n      (rst_n),
            .a_i        (bus.a[c*WIDTH +: WIDTH]),
            .ctrl_i     (bus.ctrl[c]),
            .flt_we_i   (we_c[c]),
            .flt_type_i (bus.flt_type),
            .o_o        (bus.o[c*WIDTH +: WIDTH]),
            .driven_o   (bus.o_driven[c]),
            .valid_o    (bus.o_valid[c]),
            .decay_o    (bus.decay_evt[c])
        );
    end

endmodule

// File: tb/tb_pass_switch_bank.sv
// Scoreboard bench for pass_switch_bank: NMOS/hold-3, PMOS/hold-3 and NMOS/hold-0 instances.
module tb_pass_switch_bank;
    import pass_switch_pkg::*;

    typedef struct {
        bit          chk;
        int          sel;
        logic [31:0] o;
        logic [3:0]  drv;
        logic [3:0]  vld;
        logic [3:0]  dec;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pass_switch_bank_if #(.WIDTH(8), .CHANNELS(4)) bm ();
    pass_switch_bank_if #(.WIDTH(8), .CHANNELS(4)) bp ();
    pass_switch_bank_if #(.WIDTH(8), .CHANNELS(4)) bz ();

    pass_switch_bank #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(3), .ACTIVE_HIGH(1'b1))
        u_main (.clk(clk), .rst_n(rst_n), .bus(bm));
    pass_switch_bank #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(3), .ACTIVE_HIGH(1'b0))
        u_pmos (.clk(clk), .rst_n(rst_n), .bus(bp));
    pass_switch_bank #(.WIDTH(8), .CHANNELS(4), .HOLD_CYCLES(0), .ACTIVE_HIGH(1'b1))
        u_h0 (.clk(clk), .rst_n(rst_n), .bus(bz));

    // Queue the response expected after the next rising edge, then advance one cycle
    task automatic cyc(input bit chk, input int sel, input logic [31:0] o,
                       input logic [3:0] drv, input logic [3:0] vld,
                       input logic [3:0] dec, input string nm);
        exp_t e;
        e.chk = chk; e.sel = sel; e.o = o; e.drv = drv; e.vld = vld; e.dec = dec; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare one queued expectation per cycle on the falling edge
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ao;
        logic [3:0]  ad, av, ae;
        if (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                1:       begin ao = bp.o; ad = bp.o_driven; av = bp.o_valid; ae = bp.decay_evt; end
                2:       begin ao = bz.o; ad = bz.o_driven; av = bz.o_valid; ae = bz.decay_evt; end
                default: begin ao = bm.o; ad = bm.o_driven; av = bm.o_valid; ae = bm.decay_evt; end
            endcase
            if (e.chk) begin
                checks++;
                if (ao !== e.o || ad !== e.drv || av !== e.vld || ae !== e.dec) begin
                    errors++;
                    $display("FAIL %s: got o=%h drv=%b vld=%b dec=%b, want o=%h drv=%b vld=%b dec=%b",
                             e.nm, ao, ad, av, ae, e.o, e.drv, e.vld, e.dec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bm.a = '0; bm.ctrl = 4'b0000; bm.flt_we = 1'b0; bm.flt_ch = '0; bm.flt_type = 2'b00;
        bp.a = '0; bp.ctrl = 4'b1111; bp.flt_we = 1'b0; bp.flt_ch = '0; bp.flt_type = 2'b00;
        bz.a = '0; bz.ctrl = 4'b0000; bz.flt_we = 1'b0; bz.flt_ch = '0; bz.flt_type = 2'b00;
        #1;
        cyc(0, 0, 32'h0, 4'h0, 4'h0, 4'h0, "init");
        cyc(1, 0, 32'h0, 4'h0, 4'h0, 4'h0, "reset_main");
        cyc(1, 1, 32'h0, 4'h0, 4'h0, 4'h0, "reset_pmos");
        cyc(1, 2, 32'h0, 4'h0, 4'h0, 4'h0, "reset_hold0");
        rst_n = 1'b1;

        // Basic drive of channel 0
        bm.ctrl = 4'b0001; bm.a = 32'h0000_00A5;
        cyc(1, 0, 32'h0000_00A5, 4'b0001, 4'b0001, 4'h0, "t1_drive");

        // Keeper retention and decay with HOLD_CYCLES=3
        bm.a = 32'h0000_003C;
        cyc(1, 0, 32'h0000_003C, 4'b0001, 4'b0001, 4'h0, "t2_drive");
        bm.ctrl = 4'b0000;
        cyc(1, 0, 32'h0000_003C, 4'b0000, 4'b0001, 4'h0, "t2_off1");
        cyc(1, 0, 32'h0000_003C, 4'b0000, 4'b0001, 4'h0, "t2_off2");
        cyc(1, 0, 32'h0,         4'b0000, 4'b0000, 4'b0001, "t2_off3_decay");
        cyc(1, 0, 32'h0,         4'b0000, 4'b0000, 4'h0, "t2_off4");

        // Stuck-closed takes effect one cycle after the write
        bm.a = 32'h0000_7700; bm.flt_we = 1'b1; bm.flt_ch = 2'd1; bm.flt_type = 2'b10;
        cyc(1, 0, 32'h0, 4'h0, 4'h0, 4'h0, "t3_closed_wr");
        bm.flt_we = 1'b0;
        cyc(1, 0, 32'h0000_7700, 4'b0010, 4'b0010, 4'h0, "t3_closed_on");

        // Stuck-open overrides ctrl=1 after the write edge
        bm.ctrl = 4'b0010; bm.flt_we = 1'b1; bm.flt_type = 2'b01;
        cyc(1, 0, 32'h0000_7700, 4'b0010, 4'b0010, 4'h0, "t3_open_wr");
        bm.flt_we = 1'b0;
        cyc(1, 0, 32'h0000_7700, 4'b0000, 4'b0010, 4'h0, "t3_open_off1");
        cyc(1, 0, 32'h0000_7700, 4'b0000, 4'b0010, 4'h0, "t3_open_off2");
        cyc(1, 0, 32'h0,         4'b0000, 4'b0000, 4'b0010, "t3_open_decay");

        // Reserved code 11 clears the stuck-open behaviour
        bm.flt_we = 1'b1; bm.flt_type = 2'b11;
        cyc(1, 0, 32'h0, 4'h0, 4'h0, 4'h0, "t3_rsvd_wr");
        bm.flt_we = 1'b0;
        cyc(1, 0, 32'h0000_7700, 4'b0010, 4'b0010, 4'h0, "t3_rsvd_on");

        // All channels decay together
        bm.ctrl = 4'b1111; bm.a = 32'h1122_3344;
        cyc(1, 0, 32'h1122_3344, 4'b1111, 4'b1111, 4'h0, "all_drive");
        bm.ctrl = 4'b0000;
        cyc(1, 0, 32'h1122_3344, 4'b0000, 4'b1111, 4'h0, "all_off1");
        cyc(1, 0, 32'h1122_3344, 4'b0000, 4'b1111, 4'h0, "all_off2");
        cyc(1, 0, 32'h0,         4'b0000, 4'b0000, 4'b1111, "all_decay");

        // Conduction returning on the expiry edge wins over decay
        bm.ctrl = 4'b0001; bm.a = 32'h0000_00AA;
        cyc(1, 0, 32'h0000_00AA, 4'b0001, 4'b0001, 4'h0, "race_drive");
        bm.ctrl = 4'b0000;
        cyc(1, 0, 32'h0000_00AA, 4'b0000, 4'b0001, 4'h0, "race_off1");
        cyc(1, 0, 32'h0000_00AA, 4'b0000, 4'b0001, 4'h0, "race_off2");
        bm.ctrl = 4'b0001; bm.a = 32'h0000_00BB;
        cyc(1, 0, 32'h0000_00BB, 4'b0001, 4'b0001, 4'h0, "race_redrive");

        // Reset mid-hold with ch3 stuck-open and a simultaneous fault write
        bm.ctrl = 4'b1000; bm.a = 32'h5A00_0000;
        bm.flt_we = 1'b1; bm.flt_ch = 2'd3; bm.flt_type = 2'b01;
        cyc(1, 0, 32'h5A00_00BB, 4'b1000, 4'b1001, 4'h0, "t6_ch3_wr");
        bm.flt_we = 1'b0;
        cyc(1, 0, 32'h5A00_00BB, 4'b0000, 4'b1001, 4'h0, "t6_hold");
        rst_n = 1'b0; bm.flt_we = 1'b1;
        cyc(1, 0, 32'h0, 4'h0, 4'h0, 4'h0, "t6_reset");
        rst_n = 1'b1; bm.flt_we = 1'b0;
        cyc(1, 0, 32'h5A00_0000, 4'b1000, 4'b1000, 4'h0, "t6_fault_cleared");

        // PMOS polarity: only ctrl=0 conducts
        bp.ctrl = 4'b1110; bp.a = 32'h0000_0081;
        cyc(1, 1, 32'h0000_0081, 4'b0001, 4'b0001, 4'h0, "t4_pmos_on");
        bp.ctrl = 4'b1111;
        cyc(1, 1, 32'h0000_0081, 4'b0000, 4'b0001, 4'h0, "t4_pmos_off1");

        // No retention: first off edge decays
        bz.ctrl = 4'b0100; bz.a = 32'h00FF_0000;
        cyc(1, 2, 32'h00FF_0000, 4'b0100, 4'b0100, 4'h0, "t5_h0_drive");
        bz.ctrl = 4'b0000;
        cyc(1, 2, 32'h0, 4'b0000, 4'b0000, 4'b0100, "t5_h0_decay");
        cyc(1, 2, 32'h0, 4'b0000, 4'b0000, 4'h0, "t5_h0_idle");

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pass_switch_bank.md
# pass_switch_bank

Parametrised, clocked successor of the single NMOS pass-gate cell: `CHANNELS` independent `WIDTH`-bit pass switches with selectable polarity, a charge-retention keeper that holds the last passed value for a bounded number of cycles, and per-channel injectable stuck-open/stuck-closed faults. It is a switch-level device model for the fault-simulation test cases. Patterns are applied on `a`/`ctrl` and responses are captured from `o`/`o_valid`.

## Interface
Parameters:
- `WIDTH`, 8: data bits per channel.
- `CHANNELS`, 4: number of independent switches, minimum 1.
- `HOLD_CYCLES`, 15: number of off cycles the keeper retains data. A value of 0 means no retention.
- `ACTIVE_HIGH`, 1: 1 selects NMOS behaviour (conducts on `ctrl`=1); 0 selects PMOS behaviour (conducts on `ctrl`=0).

Ports:
- `clk`  in  1  the single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `a`  in  CHANNELS*WIDTH  source data; channel c occupies bits [c*WIDTH +: WIDTH].
- `ctrl`  in  CHANNELS  gate control, one bit per channel.
- `flt_we`  in  1  fault-register write strobe.
- `flt_ch`  in  $clog2(CHANNELS) (min 1)  channel to write.
- `flt_type`  in  2  fault code: 00 none, 01 stuck-open, 10 stuck-closed, 11 reserved (treated as none).
- `o`  out  CHANNELS*WIDTH  registered channel output.
- `o_driven`  out  CHANNELS  the channel conducted in the last cycle.
- `o_valid`  out  CHANNELS  `o` holds a driven or retained value.
- `decay_evt`  out  CHANNELS  one-cycle pulse when the channel's retention expires.

## Operation
Effective conduction for channel c:
- `on` = (`ctrl`[c] == `ACTIVE_HIGH`).
- Stuck-open forces `on`=0.
- Stuck-closed forces `on`=1.

Per-channel state machine:
- States: DECAYED, DRIVEN, HOLDING.
- Any state with `on`: next state DRIVEN. `o` ← `a`, `o_driven`=1, `o_valid`=1, hold counter ← 0.
- DRIVEN or HOLDING with !`on`, when counter+1 < `HOLD_CYCLES`: next state HOLDING. `o` is unchanged, `o_driven`=0, `o_valid`=1, counter increments.
- DRIVEN or HOLDING with !`on`, when counter+1 ≥ `HOLD_CYCLES`: next state DECAYED. `o` ← 0, `o_valid`=0, and `decay_evt`=1 for exactly that cycle.
- DECAYED with !`on`: stays DECAYED. `o`=0, `o_valid`=0, `decay_evt`=0.
- The counter width is $clog2(`HOLD_CYCLES`+1), minimum 1. The counter never wraps.

Fault register:
- Holds one 2-bit code per channel.
- When `flt_we`=1, entry `flt_ch` ← `flt_type`.
- When `flt_ch` ≥ `CHANNELS`, the write is ignored.

Reset, while `rst_n`=0 at a rising edge:
- All channels go to DECAYED.
- `o`=0, `o_driven`=0, `o_valid`=0, `decay_evt`=0.
- All fault codes are set to none.
- Counters are cleared.
- Reset takes priority over every other input, including mid-hold and a simultaneous fault write.

## Timing
- Latency from `a`/`ctrl` to `o`/`o_driven`/`o_valid`/`decay_evt` is one cycle. All outputs are registered.
- A fault write sampled at edge k governs conduction sampled at edge k+1. At edge k the old fault code applies.
- With `HOLD_CYCLES`=N≥1, a channel that goes off after DRIVEN:
  - keeps `o_valid`=1 for N−1 cycles;
  - drops `o_valid` on the Nth off edge, together with `decay_evt`.
- With `HOLD_CYCLES`=0, the first off edge after DRIVEN goes directly to DECAYED with `decay_evt`=1.
- When `on` returns in the same cycle the counter would expire, DRIVEN wins and there is no `decay_evt`.
- Channels are fully independent, so several `decay_evt` bits may pulse together.

## Structure
Shared package `pass_switch_pkg`:
- `flt_t` enum: `FLT_NONE`, `FLT_OPEN`, `FLT_CLOSED`.
- `sw_state_t` enum: `SW_DECAYED`, `SW_DRIVEN`, `SW_HOLDING`.
- Helper function for the counter width.

Sub-module `pass_switch_cell`:
- Implements one channel: state machine, counter, data register and fault code.
- Instantiated `CHANNELS` times by a generate loop.
- The top level holds only the fault-write decode and the bus slicing.

## Test plan
Defaults unless noted: `WIDTH`=8, `CHANNELS`=4, `HOLD_CYCLES`=3, `ACTIVE_HIGH`=1.

1. Reset, then `ctrl`=4'b0001 and `a`[7:0]=8'hA5 -> next cycle `o`[7:0]=8'hA5, `o_driven`=4'b0001, `o_valid`=4'b0001, all other channels 0.
2. Ch0 driven with 8'h3C, then `ctrl`=0 for 4 cycles:
   - off cycles 1–2: `o`=8'h3C, `o_valid`=1;
   - off cycle 3: `o`=0, `o_valid`=0, `decay_evt`[0]=1;
   - off cycle 4: `decay_evt`[0]=0.
3. Write `flt_ch`=1, `flt_type`=10 (stuck-closed) with `ctrl`[1]=0 and `a`[15:8]=8'h77:
   - cycle after the write: ch1 unaffected;
   - the following cycle: `o`[15:8]=8'h77, `o_driven`[1]=1.
   - Then write stuck-open with `ctrl`[1]=1: ch1 enters hold and decays after 3 cycles.
4. `ACTIVE_HIGH`=0, `ctrl`=4'b1110, `a`[7:0]=8'h81 -> only ch0 conducts: `o`[7:0]=8'h81, `o_driven`=4'b0001.
5. `HOLD_CYCLES`=0: drive ch2 with 8'hFF, then turn it off -> on the first off edge `o_valid`[2]=0, `o`[23:16]=0, `decay_evt`[2]=1.
6. `rst_n`=0 asserted during HOLDING with ch3 stuck-open -> next cycle all outputs are 0. Then `ctrl`[3]=1 with `a`[31:24]=8'h5A -> `o`[31:24]=8'h5A, because reset cleared the fault.
